// File: rtl/irq_priority_ctrl.sv
// Edge-capturing 16-source interrupt controller with a req/ack handshake and a request timeout.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; the default is fixed priority with bit 0 highest.
module irq_priority_ctrl #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] irq_in,
  input  logic [15:0] mask_in,
  input  logic        irq_ack,
  output logic        irq_req,
  output logic [3:0]  irq_id,
  output logic [15:0] pending_out,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_prev;
  logic [15:0] r_pend;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic [3:0]  r_id;
  logic        r_tmo;

  logic [15:0] w_rise;
  logic [15:0] w_elig;
  logic [15:0] w_clr;
  logic [3:0]  w_sel;
  logic        w_any;
  logic        w_hit;
  logic        w_grant;
  logic        w_ack_done;
  logic        w_tmo_done;

  assign w_rise = irq_in & ~r_prev;
  assign w_elig = r_pend & ~mask_in;
  assign w_hit  = (r_cnt == 8'(TIMEOUT - 1));

`ifdef IRQ_ROUND_ROBIN_EN
  logic [3:0] r_last;

  // Descending scan so the smallest offset from the pointer wins.
  always_comb begin
    logic [3:0] idx;
    w_sel = '0;
    w_any = 1'b0;
    idx   = '0;
    for (int k = 15; k >= 0; k--) begin
      idx = r_last + 4'(k + 1);
      if (w_elig[idx]) begin
        w_sel = idx;
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 4'hf;
    end else if (w_ack_done || w_tmo_done) begin
      r_last <= r_id;
    end
  end
`else
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_sel = 4'(i);
        w_any = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (enable && w_any) w_next = S_REQ;
      S_REQ:  if (irq_ack || w_hit) w_next = S_GAP;
      S_GAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant    = (r_state == S_IDLE) && enable && w_any;
    w_ack_done = (r_state == S_REQ) && irq_ack;
    w_tmo_done = (r_state == S_REQ) && !irq_ack && w_hit;
    w_clr      = w_ack_done ? (16'd1 << r_id) : 16'd0;
  end

  // A fresh edge on the line being cleared re-arms it in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
      r_req  <= 1'b0;
      r_id   <= '0;
      r_tmo  <= 1'b0;
    end else begin
      r_prev <= irq_in;
      r_pend <= (r_pend & ~w_clr) | w_rise;
      r_req  <= (w_next == S_REQ);
      r_tmo  <= w_tmo_done;
      if (w_grant) begin
        r_id  <= w_sel;
        r_cnt <= '0;
      end else if (r_state == S_REQ) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign irq_req     = r_req;
  assign irq_id      = r_id;
  assign pending_out = r_pend;
  assign timeout_err = r_tmo;

endmodule

// File: doc/irq_priority_ctrl.md
IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 8: number of cycles irq_req is held without irq_ack before the request is abandoned; legal range 2..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 enable  input  1  global enable; 0 blocks new requests from being issued.
REQ-005 irq_in  input  16  interrupt source lines; rising edges are captured.
REQ-006 mask_in  input  16  per-source mask; 1 = source masked from selection, capture still occurs.
REQ-007 irq_ack  input  1  consumer acknowledge of the current request.
REQ-008 irq_req  output  1  registered request to consumer.
REQ-009 irq_id  output  4  registered binary index of the serviced source; valid while irq_req=1.
REQ-010 pending_out  output  16  registered pending vector.
REQ-011 timeout_err  output  1  registered one-cycle pulse on request abandonment.

Function
REQ-012 Block SHALL register irq_in each cycle (irq_prev) and set pending[i] when irq_in[i]=1 and irq_prev[i]=0.
REQ-013 Eligible vector SHALL be pending & ~mask_in; selection SHALL be the lowest eligible index (bit 0 highest priority) unless IRQ_ROUND_ROBIN_EN is defined.
REQ-014 FSM states SHALL be IDLE, REQ, GAP.
REQ-015 IDLE: if enable=1 and eligible vector nonzero, latch selected index into irq_id, set irq_req=1, clear timeout counter, go to REQ; else stay.
REQ-016 REQ: irq_req=1 and irq_id SHALL remain stable; mask_in or enable changes SHALL NOT retract the request.
REQ-017 REQ with irq_ack=1: clear pending[irq_id], drive irq_req=0, go to GAP.
REQ-018 REQ without irq_ack: increment counter; when counter reaches TIMEOUT-1 without ack, drive irq_req=0, pulse timeout_err for one cycle, leave pending[irq_id] set, go to GAP.
REQ-019 GAP: one cycle with irq_req=0, then IDLE unconditionally.
REQ-020 irq_ack while in IDLE or GAP SHALL be ignored.
REQ-021 A new rising edge on irq_in[irq_id] in the same cycle as its ack-clear SHALL leave pending[irq_id]=1 (set wins).
REQ-022 Latency: edge sampled at clock k sets pending at k; irq_req=1 after clock k+1 (2 clocks) when FSM is in IDLE and source is highest eligible.
REQ-023 Minimum spacing between consecutive requests SHALL be 2 cycles with irq_req=0 (GAP, then IDLE decision).

Reset
REQ-024 With reset=1 at a rising clk edge: state=IDLE, pending=0, irq_prev=0, counter=0, irq_req=0, irq_id=0, timeout_err=0, pending_out=0; round-robin pointer=15 when compiled in.
REQ-025 Reset SHALL take precedence over all other inputs, including mid-request and same-cycle irq_ack.
REQ-026 An irq_in line already high on the first clock after reset SHALL be captured as an edge (irq_prev=0).

Configuration
REQ-027 Macro IRQ_ROUND_ROBIN_EN defined: selection SHALL start at index (last_granted+1) mod 16 and wrap, last_granted updating on ack or timeout; undefined: fixed lowest-index priority, no pointer register.

Verification
REQ-028 Reset, then irq_in=16'h0001 edge, mask 0, enable 1 -> irq_req=1, irq_id=0 two clocks later; ack -> pending_out=16'h0000, irq_req=0.
REQ-029 Simultaneous edges on bits 3 and 9 (fixed priority) -> grants irq_id=3 then irq_id=9, each after ack, separated by 2 idle cycles.
REQ-030 Edge on bit 5, no ack, TIMEOUT=8 -> irq_req high 8 cycles, timeout_err pulses once, pending_out=16'h0020, re-request irq_id=5 after GAP.
REQ-031 mask_in=16'h0004 with edge on bit 2 -> pending_out=16'h0004, no irq_req; unmask -> irq_req with irq_id=2.
REQ-032 reset asserted during REQ with irq_ack=1 same cycle -> all outputs 0 next cycle, pending cleared.
REQ-033 IRQ_ROUND_ROBIN_EN: bits 0 and 1 re-edged after every ack -> grants alternate 0,1,0,1.
